// File: rtl/peri_arb.sv
// Two-master arbiter in front of a single peripheral port: one access per grant,
// issued as a one-cycle strobe followed by a one-cycle ready pulse back to the master.
//   state  | meaning
//   IDLE   | no transaction; arbitrate and latch winner's request
//   ACCESS | drive p_we or p_re for one cycle with the latched request
//   RESP   | pulse ready (and rdata) to the granted master
module peri_arb #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  gnt,
    output logic        busy,
    output logic [31:0] p_address,
    output logic [31:0] p_write_data,
    output logic        p_we,
    output logic        p_re,
    input  logic [31:0] p_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_nxt;
    // last_gnt doubles as the current grant while busy: 0 = m0, 1 = m1
    logic        last_gnt;
    logic        winner;
    logic        load;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    always_comb begin
        if (!m0_req) begin
            winner = 1'b1;
        end else if (RR_EN && m1_req) begin
            winner = ~last_gnt;
        end else begin
            winner = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (load) begin
                last_gnt <= winner;
                we_q     <= winner ? m1_we    : m0_we;
                addr_q   <= winner ? m1_addr  : m0_addr;
                wdata_q  <= winner ? m1_wdata : m0_wdata;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        busy      = 1'b0;
        gnt       = 2'b00;
        p_we      = 1'b0;
        p_re      = 1'b0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = 32'd0;
        m1_rdata  = 32'd0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_nxt = ACCESS;
                    load      = 1'b1;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                busy      = 1'b1;
                gnt       = last_gnt ? 2'b10 : 2'b01;
                p_we      = we_q;
                p_re      = ~we_q;
            end
            RESP: begin
                state_nxt = IDLE;
                busy      = 1'b1;
                gnt       = last_gnt ? 2'b10 : 2'b01;
                m0_ready  = ~last_gnt;
                m1_ready  = last_gnt;
                if (!we_q) begin
                    if (last_gnt) begin
                        m1_rdata = p_read_data;
                    end else begin
                        m0_rdata = p_read_data;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign p_address    = addr_q;
    assign p_write_data = wdata_q;

endmodule

// File: tb/tb_peri_arb.sv
// Self-checking bench for peri_arb: a round-robin instance checked through
// strobe/response scoreboards, plus a fixed-priority instance for starvation.
module tb_peri_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
    logic [31:0] pdata = '0, p_read_data = '0, fp_p_read_data = '0;

    logic        m0_ready, m1_ready, busy, p_we, p_re;
    logic [31:0] m0_rdata, m1_rdata, p_address, p_write_data;
    logic [1:0]  gnt;
    logic        fp_m0_ready, fp_m1_ready, fp_busy, fp_p_we, fp_p_re;
    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_p_address, fp_p_write_data;
    logic [1:0]  fp_gnt;

    peri_arb #(.RR_EN(1'b1)) u_rr (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .gnt(gnt), .busy(busy), .p_address(p_address), .p_write_data(p_write_data),
        .p_we(p_we), .p_re(p_re), .p_read_data(p_read_data)
    );

    peri_arb #(.RR_EN(1'b0)) u_fp (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
        .gnt(fp_gnt), .busy(fp_busy), .p_address(fp_p_address), .p_write_data(fp_p_write_data),
        .p_we(fp_p_we), .p_re(fp_p_re), .p_read_data(fp_p_read_data)
    );

    always #5 clk = ~clk;

    // Peripheral models: read data registered on the p_re edge
    always @(posedge clk) if (p_re) p_read_data <= pdata;
    always @(posedge clk) if (fp_p_re) fp_p_read_data <= pdata;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          cyc;
        logic [1:0]  gnt;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic [1:0]  req;
        logic        we0, we1;
        logic [31:0] a0, a1, d0, d1, pd;
        logic [1:0]  egnt;
        logic [31:0] erdata;
    } vec_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic we0, input logic [31:0] a0,
                                input logic [31:0] d0, input logic we1, input logic [31:0] a1,
                                input logic [31:0] d1, input logic [31:0] pd,
                                input logic [1:0] egnt, input logic [31:0] erdata);
        vec_t v;
        v.req = req; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.we1 = we1; v.a1 = a1; v.d1 = d1; v.pd = pd;
        v.egnt = egnt; v.erdata = erdata;
        return v;
    endfunction

    // Monitor: samples 3 time units after each rising edge
    always begin
        acc_t a;
        rsp_t r;
        @(posedge clk);
        cyc++;
        #3;
        if (!reset) begin
            if (busy) chk("gnt_onehot", 32'(gnt == 2'b01 || gnt == 2'b10), 32'd1);
            else      chk("gnt_idle", 32'(gnt), 32'd0);
            chk("strobe_excl", 32'(p_we & p_re), 32'd0);
            if (p_we || p_re) begin
                if (acc_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_strobe: got we=%b re=%b expected none (cycle %0d)", p_we, p_re, cyc);
                end else begin
                    a = acc_q.pop_front();
                    chk("strobe_cycle", 32'(cyc), 32'(a.cyc));
                    chk("strobe_gnt", 32'(gnt), 32'(a.gnt));
                    chk("strobe_we", 32'(p_we), 32'(a.we));
                    chk("strobe_addr", p_address, a.addr);
                    if (a.we) chk("strobe_wdata", p_write_data, a.wdata);
                end
            end
            if (m0_ready || m1_ready) begin
                if (rsp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_ready: got %b%b expected none (cycle %0d)", m1_ready, m0_ready, cyc);
                end else begin
                    r = rsp_q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(r.cyc));
                    chk("ready_who", 32'({m1_ready, m0_ready}), 32'(r.gnt));
                    chk("rdata_granted", r.gnt[0] ? m0_rdata : m1_rdata, r.rdata);
                    chk("rdata_other", r.gnt[0] ? m1_rdata : m0_rdata, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vec_t v;
        int   c0, n0, n1;

        vecs[0] = mk(2'b01, 1'b0, 32'h10, 32'h0,        1'b0, 32'h999, 32'h0,    32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF);
        vecs[1] = mk(2'b10, 1'b0, 32'h888, 32'h0,       1'b1, 32'h20,  32'hA5,   32'h1111_1111, 2'b10, 32'h0);
        vecs[2] = mk(2'b11, 1'b1, 32'h30, 32'h11,       1'b0, 32'h40,  32'h0,    32'h2222_2222, 2'b01, 32'h0);
        vecs[3] = mk(2'b11, 1'b0, 32'h50, 32'h0,        1'b0, 32'h60,  32'h0,    32'h1234_5678, 2'b10, 32'h1234_5678);
        vecs[4] = mk(2'b11, 1'b1, 32'h70, 32'hCAFE,     1'b1, 32'h80,  32'hBEEF, 32'h3333_3333, 2'b01, 32'h0);
        vecs[5] = mk(2'b10, 1'b1, 32'h777, 32'h1,       1'b0, 32'h90,  32'h0,    32'h55AA,      2'b10, 32'h55AA);
        vecs[6] = mk(2'b01, 1'b1, 32'hA0, 32'hFFFF_FFFF, 1'b1, 32'h666, 32'h2,   32'h4444_4444, 2'b01, 32'h0);
        vecs[7] = mk(2'b11, 1'b0, 32'hB0, 32'h0,        1'b0, 32'hC0,  32'h0,    32'hA5A5_0000, 2'b10, 32'hA5A5_0000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_p_we", 32'(p_we), 32'd0);
        chk("rst_p_re", 32'(p_re), 32'd0);
        chk("rst_m0_ready", 32'(m0_ready), 32'd0);
        chk("rst_m1_ready", 32'(m1_ready), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_p_address", p_address, 32'd0);
        chk("rst_p_write_data", p_write_data, 32'd0);
        reset = 1'b0;

        // Table: one transaction per entry; inputs corrupted and reqs dropped right after grant
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            @(negedge clk);
            m0_req = v.req[0]; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
            m1_req = v.req[1]; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
            pdata  = v.pd;
            acc_q.push_back('{cyc: cyc + 1, gnt: v.egnt,
                              we: v.egnt[0] ? v.we0 : v.we1,
                              addr: v.egnt[0] ? v.a0 : v.a1,
                              wdata: v.egnt[0] ? v.d0 : v.d1});
            rsp_q.push_back('{cyc: cyc + 2, gnt: v.egnt, rdata: v.erdata});
            @(posedge clk);
            #1;
            m0_addr = ~m0_addr; m1_addr = ~m1_addr; m0_we = ~m0_we; m1_we = ~m1_we;
            m0_wdata = ~m0_wdata; m1_wdata = ~m1_wdata;
            m0_req = 1'b0; m1_req = 1'b0;
            repeat (2) @(posedge clk);
        end

        // Reset in ACCESS aborts the read: strobe drops at once, no ready
        @(negedge clk);
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h300; m1_req = 1'b0; pdata = 32'h777;
        @(posedge clk);
        #1;
        chk("abort_pre_p_re", 32'(p_re), 32'd1);
        reset = 1'b1;
        m0_req = 1'b0;
        #1;
        chk("abort_p_re", 32'(p_re), 32'd0);
        chk("abort_p_we", 32'(p_we), 32'd0);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_m0_ready", 32'(m0_ready), 32'd0);
        chk("abort_fp_p_re", 32'(fp_p_re), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Both masters held: RR alternates starting with m0, fixed priority starves m1
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = 32'h0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_wdata = 32'h77;
        pdata  = 32'h0BAD_F00D;
        c0 = cyc;
        for (int k = 0; k < 4; k++) begin
            acc_q.push_back('{cyc: c0 + 1 + 3 * k, gnt: (k % 2 == 0) ? 2'b01 : 2'b10,
                              we: (k % 2 == 1), addr: (k % 2 == 0) ? 32'h100 : 32'h200,
                              wdata: 32'h77});
            rsp_q.push_back('{cyc: c0 + 2 + 3 * k, gnt: (k % 2 == 0) ? 2'b01 : 2'b10,
                              rdata: (k % 2 == 0) ? 32'h0BAD_F00D : 32'h0});
        end
        n0 = 0;
        n1 = 0;
        repeat (12) begin
            @(posedge clk);
            #2;
            if (fp_m0_ready) n0++;
            if (fp_m1_ready) n1++;
            if (fp_busy) chk("fp_gnt", 32'(fp_gnt), 32'd1);
        end
        @(negedge clk);
        m0_req = 1'b0; m1_req = 1'b0;
        chk("fp_m0_grants", 32'(n0), 32'd4);
        chk("fp_m1_starved", 32'(n1), 32'd0);

        repeat (4) @(posedge clk);
        #4;
        chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
